// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the sequence-scan controller: FSM state encoding
// and default geometry for the job data path.
package seq_scan_ctrl_pkg;

  // Default job geometry: DW-bit pattern, CW-bit length / hit counter.
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 4;

  // FSM state encoding, fixed 3-bit values so the state is observable
  // consistently across the codebase.
  localparam logic [2:0] IDLE_ENC  = 3'd0;
  localparam logic [2:0] CLR_ENC   = 3'd1;
  localparam logic [2:0] SHIFT_ENC = 3'd2;
  localparam logic [2:0] DRAIN_ENC = 3'd3;
  localparam logic [2:0] DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE_ENC,
    ST_CLR   = CLR_ENC,
    ST_SHIFT = SHIFT_ENC,
    ST_DRAIN = DRAIN_ENC,
    ST_DONE  = DONE_ENC
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_piso.sv
// Loadable MSB-first parallel-in/serial-out shift register. The current
// serial bit is always the MSB; a shift moves the next bit into the MSB.
module seq_piso
  import seq_scan_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic [DW-1:0] din_i,
  output logic          msb_o
);

  logic [DW-1:0] sr_q;
  logic [DW-1:0] sr_d;

  // Next shift-register contents: load has priority over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[DW-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift-register storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= {DW{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[DW-1];

endmodule

// File: rtl/seq_scan_ctrl.sv
// Sequence-scan controller: shifts a job pattern serially into an external
// detector and records which bits the detector reacted to. The detector is
// a Moore machine, so its response to bit k is sampled one cycle later.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] data,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          seq_rst,
  output logic          ser_out,
  output logic          ser_vld,
  input  logic          det_in,
  output logic [CW-1:0] hit_cnt,
  output logic [DW-1:0] hit_map
);

  localparam logic [CW-1:0] LEN_MAX = CW'(DW);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [DW-1:0] MAP_ONE = DW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;
  logic [DW-1:0] hit_map_q, hit_map_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_vld_q, ser_vld_d;

  logic [CW-1:0] eff_len_s;
  logic          hit_s;
  logic [CW-1:0] hit_bit_s;
  logic          piso_load_s;
  logic          piso_shift_s;
  logic          piso_msb_s;

  seq_piso #(.DW(DW)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (piso_load_s),
    .shift_i (piso_shift_s),
    .din_i   (data),
    .msb_o   (piso_msb_s)
  );

  // Effective job length: out-of-range requests (0 or > DW) run a full word.
  always_comb begin
    eff_len_s = len;
    if ((len == {CW{1'b0}}) || (len > LEN_MAX)) begin
      eff_len_s = LEN_MAX;
    end else begin
      eff_len_s = len;
    end
  end

  // Next-state, index, hit accumulation and registered-output next values.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    hit_cnt_d    = hit_cnt_q;
    hit_map_d    = hit_map_q;
    piso_load_s  = 1'b0;
    hit_s        = 1'b0;
    hit_bit_s    = {CW{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLR;
          len_d       = eff_len_s;
          piso_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_d   = ST_SHIFT;
        idx_d     = {CW{1'b0}};
        hit_cnt_d = {CW{1'b0}};
        hit_map_d = {DW{1'b0}};
      end
      ST_SHIFT: begin
        // Detector output now reflects the previous bit on ser_out.
        if (idx_q != {CW{1'b0}}) begin
          hit_s     = det_in;
          hit_bit_s = idx_q - ONE_C;
        end else begin
          hit_s = 1'b0;
        end
        if (idx_q == (len_q - ONE_C)) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + ONE_C;
        end
      end
      ST_DRAIN: begin
        // Last bit's detector response arrives one cycle after SHIFT ends.
        hit_s     = det_in;
        hit_bit_s = len_q - ONE_C;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (hit_s) begin
      hit_cnt_d = hit_cnt_q + ONE_C;
      hit_map_d = hit_map_q | (MAP_ONE << hit_bit_s);
    end else begin
      hit_cnt_d = hit_cnt_d;
      hit_map_d = hit_map_d;
    end

    // Outputs are registered from the upcoming state so they line up with it.
    piso_shift_s = (state_d == ST_SHIFT);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    ser_vld_d    = (state_d == ST_SHIFT);
    ser_out_d    = (state_d == ST_SHIFT) ? piso_msb_s : 1'b0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      len_q     <= {CW{1'b0}};
      idx_q     <= {CW{1'b0}};
      hit_cnt_q <= {CW{1'b0}};
      hit_map_q <= {DW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ser_out_q <= 1'b0;
      ser_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      hit_cnt_q <= hit_cnt_d;
      hit_map_q <= hit_map_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ser_out_q <= ser_out_d;
      ser_vld_q <= ser_vld_d;
    end
  end

  // Detector clear follows reset immediately, and pulses low during CLR.
  assign seq_rst = rst & (state_q != ST_CLR);
  assign busy    = busy_q;
  assign done    = done_q;
  assign ser_out = ser_out_q;
  assign ser_vld = ser_vld_q;
  assign hit_cnt = hit_cnt_q;
  assign hit_map = hit_map_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [3:0] len;
  logic       busy;
  logic       done;
  logic       seq_rst;
  logic       ser_out;
  logic       ser_vld;
  logic       det_in;
  logic [3:0] hit_cnt;
  logic [7:0] hit_map;

  int n_total;
  int n_pass;

  seq_scan_ctrl #(.DW(8), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data    (data),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .seq_rst (seq_rst),
    .ser_out (ser_out),
    .ser_vld (ser_vld),
    .det_in  (det_in),
    .hit_cnt (hit_cnt),
    .hit_map (hit_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the start cycle; the task returns in the first IDLE cycle
  // after DONE (cycle el+4), so a following job starts right there.
  task automatic run_job(input string name, input logic [7:0] d, input logic [3:0] l,
                         input int el, input logic [7:0] exp_seq, input logic [7:0] det_bits,
                         input bit det_pre, input bit det_all, input int start2_c,
                         input logic [3:0] exp_cnt, input logic [7:0] exp_map);
    logic exp_so;
    data   = d;
    len    = l;
    start  = 1'b1;
    det_in = det_pre | det_all;
    for (int c = 1; c <= el + 4; c++) begin
      tick();
      start  = (c == start2_c);
      det_in = (det_pre && c <= 1) || (det_all && c <= el + 3) ||
               (c >= 3 && c <= 10 && det_bits[c-3]);
      exp_so = (c >= 2 && c <= el + 1) ? exp_seq[9-c] : 1'b0;
      chk($sformatf("%s.busy@%0d", name, c), 32'(busy), 32'(c <= el + 3));
      chk($sformatf("%s.done@%0d", name, c), 32'(done), 32'(c == el + 3));
      chk($sformatf("%s.ser_vld@%0d", name, c), 32'(ser_vld), 32'(c >= 2 && c <= el + 1));
      chk($sformatf("%s.ser_out@%0d", name, c), 32'(ser_out), 32'(exp_so));
      chk($sformatf("%s.seq_rst@%0d", name, c), 32'(seq_rst), 32'(c != 1));
      if (c >= el + 3) begin
        chk($sformatf("%s.hit_cnt@%0d", name, c), 32'(hit_cnt), 32'(exp_cnt));
        chk($sformatf("%s.hit_map@%0d", name, c), 32'(hit_map), 32'(exp_map));
      end
    end
    start  = 1'b0;
    det_in = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    data    = 8'h00;
    len     = 4'd0;
    det_in  = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ser_out", 32'(ser_out), 32'd0);
    chk("rst.ser_vld", 32'(ser_vld), 32'd0);
    chk("rst.hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst.hit_map", 32'(hit_map), 32'd0);
    chk("rst.seq_rst", 32'(seq_rst), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel.seq_rst", 32'(seq_rst), 32'd1);
    chk("rel.busy", 32'(busy), 32'd0);

    // Full job, hits after bits 2 and 7.
    run_job("jobA", 8'b01110010, 4'd8, 8, 8'b01110010, 8'b10000100, 1'b0, 1'b0, -1,
            4'd2, 8'b10000100);
    // Short job, detector stuck high; start during DONE must be ignored.
    run_job("jobB", 8'b10100000, 4'd3, 3, 8'b10100000, 8'b00000000, 1'b0, 1'b1, 6,
            4'd3, 8'b00000111);
    // Detector high only in IDLE and CLR: no hits, counters cleared.
    run_job("jobC", 8'hFF, 4'd8, 8, 8'hFF, 8'b00000000, 1'b1, 1'b0, -1,
            4'd0, 8'h00);
    // Out-of-range lengths run a full word.
    run_job("len0", 8'hA5, 4'd0, 8, 8'hA5, 8'b00000000, 1'b0, 1'b0, -1,
            4'd0, 8'h00);
    // Second start during SHIFT is dropped; next job starts in first IDLE.
    run_job("len15", 8'h3C, 4'd15, 8, 8'h3C, 8'b00000000, 1'b0, 1'b0, 4,
            4'd0, 8'h00);
    run_job("jobF", 8'h81, 4'd8, 8, 8'h81, 8'b00000001, 1'b0, 1'b0, -1,
            4'd1, 8'b00000001);

    // Reset during the 4th SHIFT cycle aborts the job.
    data  = 8'hFF;
    len   = 4'd8;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("abort.seq_rst_in_rst", 32'(seq_rst), 32'd0);
    tick();
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.ser_vld", 32'(ser_vld), 32'd0);
    chk("abort.ser_out", 32'(ser_out), 32'd0);
    chk("abort.hit_cnt", 32'(hit_cnt), 32'd0);
    chk("abort.hit_map", 32'(hit_map), 32'd0);
    chk("abort.seq_rst", 32'(seq_rst), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("abort.nodone@%0d", c), 32'(done), 32'd0);
      chk($sformatf("abort.idle@%0d", c), 32'(busy), 32'd0);
    end
    // First job after reset release runs normally.
    run_job("jobG", 8'b11000000, 4'd2, 2, 8'b11000000, 8'b00000010, 1'b0, 1'b0, -1,
            4'd1, 8'b00000010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have exactly two parameters, one per line below.
- DW, 8: maximum job length in bits; width of data and hit_map.
- CW, 4: width of len and hit_cnt; must satisfy 2^CW > DW.
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-low reset.
- start, input, 1: job request; sampled only in IDLE.
- data, input, DW: pattern word; bit DW-1 is shifted first; latched on accepted start.
- len, input, CW: number of bits to shift; latched on accepted start.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at job end.
- seq_rst, output, 1: active-low clear to detector; low while rst=0 or state=CLR.
- ser_out, output, 1: serial bit driven to detector input.
- ser_vld, output, 1: high while ser_out carries a valid job bit.
- det_in, input, 1: detector output; registered (Moore) and one cycle behind the bit it reacts to.
- hit_cnt, output, CW: number of detections in the last job.
- hit_map, output, DW: hit_map[k]=1 if det_in was high one cycle after job bit k (k=0 is the first bit shifted).

Function
REQ-003 The FSM SHALL have states IDLE, CLR, SHIFT, DRAIN and DONE.
REQ-004 IDLE->CLR SHALL occur when start=1; start in any other state SHALL be ignored, with no queuing.
REQ-005 CLR SHALL last one cycle with seq_rst=0, hit_cnt cleared and hit_map cleared, then go to SHIFT.
REQ-006 An effective length SHALL be computed at start: L=len if 1<=len<=DW; L=DW if len=0 or len>DW.
REQ-007 SHIFT SHALL last exactly L cycles with bit index i=0..L-1, ser_vld=1 and ser_out=latched data[DW-1-i].
REQ-008 In SHIFT with i>=1, det_in SHALL be sampled and attributed to bit i-1.
REQ-009 DRAIN SHALL last one cycle, ser_vld=0 and ser_out=0, with det_in attributed to bit L-1.
REQ-010 Each sampled det_in=1 SHALL set hit_map[bit] and increment hit_cnt; hit_cnt never exceeds DW, so it cannot wrap.
REQ-011 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-012 Latency: with start accepted at cycle 0, CLR is at cycle 1, SHIFT spans cycles 2..L+1, DRAIN is at L+2 and done is at L+3.
REQ-013 hit_cnt and hit_map SHALL hold their values from DONE until the next CLR.
REQ-014 A start at the same edge as the DONE->IDLE transition SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-015 det_in outside SHIFT (i>=1) and DRAIN SHALL be ignored.
REQ-016 All outputs SHALL be registered except seq_rst, which is the AND of rst with not-CLR.

Reset
REQ-017 When rst=0 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, ser_out=0, ser_vld=0, hit_cnt=0 and hit_map=0.
REQ-018 A reset during CLR, SHIFT, DRAIN or DONE SHALL abort the job with no done pulse.
REQ-019 seq_rst SHALL be 0 for the whole time rst=0.
REQ-020 The first start accepted after reset release SHALL run a complete job.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (3-bit, localparam values IDLE=0, CLR=1, SHIFT=2, DRAIN=3, DONE=4) and the defaults for DW and CW.
REQ-022 One sub-module SHALL be used: seq_piso, a loadable DW-bit MSB-first shift register with load and shift enables.
REQ-023 The top SHALL contain the FSM, the bit-index counter and the hit accumulation logic.

Verification
REQ-024 Bench stimulus: data=8'b01110010, len=8, start pulse; det_in scripted high one cycle after bits 2 and 7 -> ser_out sequence 0,1,1,1,0,0,1,0; done at cycle 11; hit_cnt=2; hit_map=8'b10000100.
REQ-025 Bench stimulus: len=3, data=8'b10100000, det_in held high throughout the job -> ser_out sequence 1,0,1; done at cycle 6; hit_cnt=3; hit_map=8'b00000111.
REQ-026 Bench stimulus: len=0 and separately len=15 -> both run 8 bits with done at cycle 11.
REQ-027 Bench stimulus: second start pulse during SHIFT -> ignored, exactly one done pulse; start at cycle 12 (first IDLE) -> new job with done at cycle 23.
REQ-028 Bench stimulus: rst=0 at the 4th SHIFT cycle -> next cycle IDLE with all outputs 0, seq_rst=0 while rst=0, no done pulse; the next job completes normally.
REQ-029 Bench stimulus: det_in=1 in IDLE and CLR, no hits in the job -> hit_cnt=0 and hit_map=0.
